// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and elaboration helpers for the binary-to-BCD converter
package bcd_pkg;

    localparam int DIGITS_DEFAULT = 8;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_adj.sv
// rtl/bcd_add3_adj.sv - double-dabble per-nibble add-3 correction
module bcd_add3_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// rtl/bin_to_bcd_converter.sv - sequential double-dabble binary to packed BCD converter
module bin_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int DATA_W = 27,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int BW = 4 * DIGITS;
    localparam longint unsigned THRESH = pow10(DIGITS);

    if (DATA_W < 4) begin : g_chk_data_w
        $error("bin_to_bcd_converter: DATA_W must be >= 4");
    end
    if (DIGITS < 1) begin : g_chk_digits
        $error("bin_to_bcd_converter: DIGITS must be >= 1");
    end

    b2b_state_t        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              overflow_q, overflow_d;

    logic [BW-1:0]     scr_adj;
    logic [BW-1:0]     scr_shift;
    logic [DATA_W-1:0] sh_shift;
    logic              load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_adj u_adj (
            .digit_i (scr_q[4*g +: 4]),
            .digit_o (scr_adj[4*g +: 4])
        );
    end

    assign scr_shift = {scr_adj[BW-2:0], sh_q[DATA_W-1]};
    assign sh_shift  = {sh_q[DATA_W-2:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                load = start;
            end
            SHIFT: begin
                scr_d = scr_shift;
                sh_d  = sh_shift;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    // Overflowed scratch is garbage; publish the saturation pattern instead.
                    bcd_d      = ovf_flag_q ? {DIGITS{4'h9}} : scr_shift;
                    overflow_d = ovf_flag_q;
                end
            end
            DONE: begin
                load    = start;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d    = SHIFT;
            sh_d       = bin;
            scr_d      = '0;
            cnt_d      = CW'(DATA_W);
            ovf_flag_d = (64'(bin) >= THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb/tb_bin_to_bcd_converter.sv - randomized self-checking bench for bin_to_bcd_converter
module tb_bin_to_bcd_converter;

    localparam int DATA_W = 27;
    localparam int DIGITS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] bin;
    logic              busy;
    logic              done;
    logic [31:0]       bcd;
    logic              overflow;

    int vectors = 0;
    int errors  = 0;

    bin_to_bcd_converter #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (v >= 100000000) return 32'h99999999;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic start_conv(input logic [DATA_W-1:0] v);
        @(posedge clk); #1;
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Entered one step after the accepting edge; leaves in the DONE cycle,
    // or just after the chained accept when chain=1.
    task automatic wait_result(input logic [DATA_W-1:0] v, input bit poke,
                               input bit chain, input logic [DATA_W-1:0] nv);
        expect_eq("busy_after_accept", 32'(busy), 32'd1);
        for (int k = 1; k <= DATA_W; k++) begin
            if (poke && (k == 3 || k == 10)) begin
                start = 1'b1;
                bin   = 27'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (k < DATA_W) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    expect_eq("busy_during_shift", {30'd0, busy, done}, 32'd2);
                end
            end
        end
        start = 1'b0;
        expect_eq("done_at_latency", 32'(done), 32'd1);
        expect_eq("busy_in_done", 32'(busy), 32'd0);
        expect_eq("bcd_value", bcd, ref_bcd(32'(v)));
        expect_eq("overflow_flag", 32'(overflow), 32'(v >= 27'd100000000));
        if (chain) begin
            start = 1'b1;
            bin   = nv;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        logic [DATA_W-1:0] rv;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            expect_eq("idle_done", 32'(done), 32'd0);
        end
        expect_eq("reset_bcd", bcd, 32'd0);
        expect_eq("reset_overflow", 32'(overflow), 32'd0);
        expect_eq("reset_busy", 32'(busy), 32'd0);

        start_conv(27'd0);
        wait_result(27'd0, 1'b0, 1'b0, '0);

        start_conv(27'd12345678);
        wait_result(27'd12345678, 1'b0, 1'b1, 27'd99999999);
        wait_result(27'd99999999, 1'b0, 1'b0, '0);

        start_conv(27'd100000000);
        wait_result(27'd100000000, 1'b0, 1'b0, '0);
        start_conv(27'd7);
        wait_result(27'd7, 1'b0, 1'b0, '0);

        start_conv(27'd8765);
        wait_result(27'd8765, 1'b1, 1'b1, 27'd134217727);
        wait_result(27'd134217727, 1'b0, 1'b0, '0);

        start_conv(27'd4321);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_eq("abort_busy", 32'(busy), 32'd0);
        expect_eq("abort_bcd", bcd, 32'd0);
        expect_eq("abort_overflow", 32'(overflow), 32'd0);
        expect_eq("abort_done", 32'(done), 32'd0);
        start_conv(27'd4321);
        wait_result(27'd4321, 1'b0, 1'b0, '0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(3) == 0) rv = DATA_W'($urandom);
            else                        rv = DATA_W'($urandom % 100000000);
            start_conv(rv);
            wait_result(rv, n[2], 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
